// File: rtl/dff_write_arbiter.sv
// dff_write_arbiter: round-robin arbiter with burst lock sharing one register among requesters
module dff_write_arbiter #(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
)(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ-1:0]           req_lock,
  input  logic [N_REQ*WIDTH-1:0]     req_data,
  output logic [N_REQ-1:0]           req_ready,
  output logic [WIDTH-1:0]           q,
  output logic [$clog2(N_REQ)-1:0]   q_src,
  output logic                       q_upd,
  output logic                       locked
);
  localparam int IW = $clog2(N_REQ);
  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_LOCKED = 1'b1;
  logic [0:0]       r_state;
  logic [IW-1:0]    r_ptr;
  logic [IW-1:0]    r_owner;
  logic [7:0]       r_cnt;
  logic [WIDTH-1:0] r_q;
  logic [IW-1:0]    r_src;
  logic             r_upd;
  logic [IW-1:0]    w_idx;
  logic             w_any;
  logic [IW-1:0]    w_gnt;
  logic             w_gnt_ok;
  logic [N_REQ-1:0] w_ready;
  logic             w_acc;
  logic [7:0]       w_cnt_nxt;
  logic             w_exit;

  function automatic logic [IW-1:0] inc(input logic [IW-1:0] v);
    return (int'(v) == N_REQ - 1) ? '0 : v + 1'b1;
  endfunction

  // round-robin search from the pointer; descending scan so the lowest offset wins
  always_comb begin
    int s;
    w_any = 1'b0;
    w_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      s = int'(r_ptr) + k;
      if (s >= N_REQ) s = s - N_REQ;
      if (req_valid[s]) begin
        w_any = 1'b1;
        w_idx = IW'(s);
      end
    end
  end

  // grant selection: the owner alone while locked, otherwise the round-robin winner
  always_comb begin
    w_gnt     = (r_state == S_LOCKED) ? r_owner : w_idx;
    w_gnt_ok  = (r_state == S_LOCKED) ? req_valid[r_owner] : w_any;
    w_ready   = (en && rst_n && w_gnt_ok) ? ({{(N_REQ-1){1'b0}}, 1'b1} << w_gnt) : '0;
    w_acc     = |w_ready;
    w_cnt_nxt = r_cnt + 8'd1;
    w_exit    = (r_state == S_LOCKED) && en &&
                (!req_valid[r_owner] || !req_lock[r_owner] || w_cnt_nxt == 8'(MAX_BURST));
  end

  // shared register capture on every accepted write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q   <= '0;
      r_src <= '0;
      r_upd <= 1'b0;
    end else begin
      r_upd <= w_acc;
      if (w_acc) begin
        r_q   <= req_data[w_gnt*WIDTH +: WIDTH];
        r_src <= w_gnt;
      end
    end
  end

  // arbitration state: pointer advance, lock entry, burst counting and release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      r_cnt   <= '0;
    end else if (r_state == S_IDLE) begin
      if (w_acc) begin
        r_ptr <= inc(w_gnt);
        if (req_lock[w_gnt] && MAX_BURST > 1) begin
          r_state <= S_LOCKED;
          r_owner <= w_gnt;
          r_cnt   <= 8'd1;
        end
      end
    end else begin
      if (w_acc) r_cnt <= w_cnt_nxt;
      if (w_exit) begin
        r_state <= S_IDLE;
        r_ptr   <= inc(r_owner);
      end
    end
  end

  assign req_ready = w_ready;
  assign q         = r_q;
  assign q_src     = r_src;
  assign q_upd     = r_upd;
  assign locked    = (r_state == S_LOCKED);
endmodule
